// File: rtl/bka8_seq_add.sv
// Multi-cycle wide adder: streams NBYTES 8-bit slices, LSB first, through a
// pair of Brent-Kung 8-bit adders, chaining the carry from cycle to cycle.

module bka8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g, p;
    logic g10, p10, g32, p32, g54, p54, g76, p76;
    logic g30, p30, g74, p74, g70;
    logic g20, g40, g50, g60;

    assign g = a & b;
    assign p = a ^ b;

    // up-sweep: pairwise, then nibble, then byte group generate/propagate
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;
    assign g70 = g74 | (p74 & g30);

    // down-sweep fills in the remaining prefix carries
    assign g50 = g54 | (p54 & g30);
    assign g20 = g[2] | (p[2] & g10);
    assign g40 = g[4] | (p[4] & g30);
    assign g60 = g[6] | (p[6] & g50);

    assign s    = p ^ {g60, g50, g40, g30, g20, g10, g[0], 1'b0};
    assign cout = g70;
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding slice idx, one slice per cycle
// DONE  | result held on out_sum/out_cout until out_ready
module bka8_seq_add #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [7:0]       a_slice, b_slice, s0, s1;
    logic             c0, c1;

    assign a_slice = a_reg[8*idx +: 8];
    assign b_slice = b_reg[8*idx +: 8];

    bka8 u0 (.a(a_slice), .b(b_slice),             .s(s0), .cout(c0));
    bka8 u1 (.a(s0),      .b({7'b0, carry_reg}),   .s(s1), .cout(c1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        sum_reg   <= '0;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[8*idx +: 8] <= s1;
                    // c0 and c1 are never both set, so OR is the true carry
                    carry_reg <= c0 | c1;
                    if (idx == IDX_W'(NBYTES - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = carry_reg;
endmodule
